// File: rtl/pwm_tone_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_tone_decoder
//  Purpose  : Measures the period and high-time of an asynchronous PWM tone.
//             Every accepted rising-edge-to-rising-edge interval is reported
//             with a one-cycle valid pulse. Intervals that are too short are
//             flagged with a one-cycle glitch pulse. A missing tone is reported
//             as a silent level.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BW          counter and output width in bits
//    TIMEOUT     cycles without a rise before the input is declared silent
//                (MIN_PERIOD < TIMEOUT < 2^BW-1)
//    MIN_PERIOD  shortest accepted period in clk cycles
//  Ports
//    clk       in   1   sole clock, rising edge
//    rst_n     in   1   asynchronous active-low reset
//    ena       in   1   decoder enable (the synchronizer runs regardless)
//    pwm_i     in   1   asynchronous PWM tone input
//    period_o  out  BW  last accepted period in clk cycles
//    high_o    out  BW  high-time of that period in clk cycles
//    valid_o   out  1   one-cycle pulse when period_o/high_o update
//    glitch_o  out  1   one-cycle pulse when a period is rejected
//    silent_o  out  1   level, 1 = no tone present
// ============================================================================
module pwm_tone_decoder #(
  parameter int            BW         = 24,
  parameter logic [BW-1:0] TIMEOUT    = 24'd2400000,
  parameter logic [BW-1:0] MIN_PERIOD = 24'd4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          pwm_i,
  output logic [BW-1:0] period_o,
  output logic [BW-1:0] high_o,
  output logic          valid_o,
  output logic          glitch_o,
  output logic          silent_o
);

  localparam logic [BW-1:0] CNT_MAX = {BW{1'b1}};
  localparam logic [BW-1:0] CNT_ONE = {{(BW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t        state;

  // Input conditioning: two-flop synchronizer producing s.
  logic          sync_ff1;
  logic          s;
  // s_d is s delayed by one cycle. rise is registered at the same time, so
  // rise and s_d always describe the same sample of s. The measurement logic
  // uses only this aligned pair.
  logic          s_d;
  logic          rise;

  logic [BW-1:0] per_cnt;
  logic [BW-1:0] hi_cnt;
  logic [BW-1:0] per_next;
  logic [BW-1:0] hi_next;

  // --------------------------------------------------------------------------
  // Synchronizer and edge detector: these run regardless of ena, so a tone is
  // already tracked cleanly when the decoder is re-enabled.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1 <= 1'b0;
      s        <= 1'b0;
      s_d      <= 1'b0;
      rise     <= 1'b0;
    end else begin
      sync_ff1 <= pwm_i;
      s        <= sync_ff1;
      s_d      <= s;
      rise     <= s & ~s_d;
    end
  end

  // Saturating increments. The counters stick at all-ones and never wrap.
  always_comb begin
    per_next = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;
    hi_next  = (hi_cnt  == CNT_MAX) ? hi_cnt  : hi_cnt  + CNT_ONE;
  end

  // --------------------------------------------------------------------------
  // Measurement FSM. The counter value at a rise already includes the rise
  // cycle of the previous period, because a reload sets the counters to 1.
  // As a result, per_cnt is exactly the rise-to-rise distance. The high-time
  // counter likewise includes the high rise cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      period_o <= '0;
      high_o   <= '0;
      valid_o  <= 1'b0;
      glitch_o <= 1'b0;
      silent_o <= 1'b1;
    end else begin
      valid_o  <= 1'b0;
      glitch_o <= 1'b0;
      if (!ena) begin
        // Disabled: the result outputs hold. Measurement restarts from a
        // fresh first rise.
        state   <= IDLE;
        per_cnt <= '0;
        hi_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            // First rise only starts a measurement. It has no reference
            // edge yet, so there is nothing to report.
            if (rise) begin
              per_cnt <= CNT_ONE;
              hi_cnt  <= CNT_ONE;
              state   <= MEASURE;
            end
          end
          MEASURE: begin
            // A rise wins over the timeout in the same cycle.
            if (rise) begin
              if (per_cnt >= MIN_PERIOD) begin
                period_o <= per_cnt;
                high_o   <= hi_cnt;
                valid_o  <= 1'b1;
                silent_o <= 1'b0;
              end else begin
                glitch_o <= 1'b1;
              end
              per_cnt <= CNT_ONE;
              hi_cnt  <= CNT_ONE;
            end else if (per_cnt == TIMEOUT) begin
              state    <= IDLE;
              silent_o <= 1'b1;
              period_o <= '0;
              high_o   <= '0;
              per_cnt  <= '0;
              hi_cnt   <= '0;
            end else begin
              per_cnt <= per_next;
              if (s_d) begin
                hi_cnt <= hi_next;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_tone_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_tone_decoder
//  Purpose  : Self-checking bench for pwm_tone_decoder. Each stimulus task
//             pushes the expected valid/glitch events to a queue when it drives
//             a rise. The monitor pops and checks each entry when the DUT
//             pulses an output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_tone_decoder;

  localparam int          BW   = 24;
  localparam logic [23:0] TMO  = 24'd200;
  localparam logic [23:0] MINP = 24'd4;
  localparam int          LAT  = 4;   // driver edge to valid visible

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          pwm_i;
  logic [BW-1:0] period_o;
  logic [BW-1:0] high_o;
  logic          valid_o;
  logic          glitch_o;
  logic          silent_o;

  pwm_tone_decoder #(
    .BW         (BW),
    .TIMEOUT    (TMO),
    .MIN_PERIOD (MINP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .pwm_i    (pwm_i),
    .period_o (period_o),
    .high_o   (high_o),
    .valid_o  (valid_o),
    .glitch_o (glitch_o),
    .silent_o (silent_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_glitch;
    int per;
    int hi;
    bit silent;
    int rise_cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;
  int last_valid_cyc = 0;

  // Reference model state
  bit m_meas;
  int m_per;
  int m_hi;
  bit m_silent;
  int p_h;
  int p_l;

  // --------------------------------------------------------------------------
  // Monitor: compare every valid/glitch pulse against the queue
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && (valid_o || glitch_o)) begin
      if (valid_o) begin
        n_valid++;
        last_valid_cyc = cyc;
      end
      n_vec++;
      if (valid_o && glitch_o) begin
        n_err++;
        $display("FAIL overlap: valid_o=1 glitch_o=1 at cycle %0d, required at most one", cyc);
      end else if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: valid_o=%0b glitch_o=%0b at cycle %0d, required no event",
                 valid_o, glitch_o, cyc);
      end else begin
        mon_e = q.pop_front();
        n_vec++;
        if (glitch_o !== mon_e.is_glitch) begin
          n_err++;
          $display("FAIL event_kind: glitch_o=%0b, required %0b (cycle %0d)", glitch_o, mon_e.is_glitch, cyc);
        end
        n_vec++;
        if (period_o !== BW'(mon_e.per)) begin
          n_err++;
          $display("FAIL period: period_o=%0d, required %0d (cycle %0d)", period_o, mon_e.per, cyc);
        end
        n_vec++;
        if (high_o !== BW'(mon_e.hi)) begin
          n_err++;
          $display("FAIL high: high_o=%0d, required %0d (cycle %0d)", high_o, mon_e.hi, cyc);
        end
        n_vec++;
        if (silent_o !== mon_e.silent) begin
          n_err++;
          $display("FAIL silent_at_event: silent_o=%0b, required %0b (cycle %0d)", silent_o, mon_e.silent, cyc);
        end
        n_vec++;
        if (cyc - mon_e.rise_cyc !== LAT) begin
          n_err++;
          $display("FAIL latency: event %0d cycles after drive, required %0d", cyc - mon_e.rise_cyc, LAT);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_meas   = 1'b0;
    m_per    = 0;
    m_hi     = 0;
    m_silent = 1'b1;
  endtask

  // Drive one rise, then h high cycles and l low cycles. With l=0 the input
  // stays high. The caller guarantees that pwm_i is low on entry.
  task automatic rise_seg(input int h, input int l);
    int per;
    if (m_meas) begin
      per = p_h + p_l;
      if (per >= int'(MINP)) begin
        q.push_back('{1'b0, per, p_h, 1'b0, cyc});
        m_per    = per;
        m_hi     = p_h;
        m_silent = 1'b0;
      end else begin
        q.push_back('{1'b1, m_per, m_hi, m_silent, cyc});
      end
    end
    m_meas = 1'b1;
    pwm_i  = 1'b1;
    tick(h);
    if (l > 0) begin
      pwm_i = 1'b0;
      tick(l);
    end
    p_h = h;
    p_l = l;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pwm_i = 1'b0;
    ena   = 1'b1;
    tick(3);
    rst_n = 1'b1;
    model_reset();
    tick(2);
  endtask

  task automatic check_drained(input string name);
    tick(10);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained: %0d expected events never seen, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic wait_silent(input string name, input int exp_delay);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (silent_o) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_silent: silent_o stayed 0 for 1000 cycles, required 1 after %0d", name, exp_delay);
    end else begin
      if (cyc - last_valid_cyc !== exp_delay) begin
        n_err++;
        $display("FAIL %s_delay: silent after %0d cycles, required %0d", name, cyc - last_valid_cyc, exp_delay);
      end
      n_vec++;
      if (period_o !== '0 || high_o !== '0) begin
        n_err++;
        $display("FAIL %s_cleared: period_o=%0d high_o=%0d, required 0/0", name, period_o, high_o);
      end
    end
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string name);
    n_vec++;
    if (period_o !== '0) begin n_err++; $display("FAIL %s_period: period_o=%0d, required 0", name, period_o); end
    n_vec++;
    if (high_o !== '0) begin n_err++; $display("FAIL %s_high: high_o=%0d, required 0", name, high_o); end
    n_vec++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL %s_valid: valid_o=%0b, required 0", name, valid_o); end
    n_vec++;
    if (glitch_o !== 1'b0) begin n_err++; $display("FAIL %s_glitch: glitch_o=%0b, required 0", name, glitch_o); end
    n_vec++;
    if (silent_o !== 1'b1) begin n_err++; $display("FAIL %s_silent: silent_o=%0b, required 1", name, silent_o); end
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    tick(3);
    check_reset_values("reset");
    rst_n = 1'b1;
    model_reset();
    tick(2);
  endtask

  task automatic test_square();
    for (int i = 0; i < 6; i++) rise_seg(62, 63);
    check_drained("square");
    n_vec++;
    if (silent_o !== 1'b0) begin
      n_err++;
      $display("FAIL square_silent: silent_o=%0b, required 0", silent_o);
    end
    apply_reset();
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 3; i++) rise_seg(62, 63);
    rise_seg(1, 1);     // extra rise 2 cycles after a rise
    rise_seg(60, 63);
    rise_seg(62, 63);
    rise_seg(2, 2);     // period exactly MIN_PERIOD
    rise_seg(2, 1);     // period MIN_PERIOD-1
    rise_seg(60, 63);
    rise_seg(62, 63);
    rise_seg(10, 20);
    check_drained("glitch");
    apply_reset();
  endtask

  task automatic test_duty();
    for (int i = 0; i < 3; i++) rise_seg(1, 124);
    for (int i = 0; i < 3; i++) rise_seg(124, 1);
    rise_seg(10, 10);
    check_drained("duty");
    apply_reset();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) rise_seg(25, 25);
    rise_seg(25, 1);    // last rise, then the input stays low
    wait_silent("timeout_low", int'(TMO));
    check_drained("timeout_low");
    apply_reset();
  endtask

  task automatic test_const_high();
    for (int i = 0; i < 3; i++) rise_seg(25, 25);
    rise_seg(1, 0);     // last rise, then the input stays high
    wait_silent("timeout_high", int'(TMO));
    check_drained("timeout_high");
    apply_reset();
  endtask

  task automatic test_reset_mid();
    int v0;
    rise_seg(62, 63);
    rise_seg(62, 63);
    rise_seg(40, 0);    // mid high phase
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid");
    pwm_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    model_reset();
    tick(2);
    v0 = n_valid;
    rise_seg(62, 63);
    rise_seg(10, 30);
    check_drained("reset_mid");
    n_vec++;
    if (n_valid - v0 !== 1) begin
      n_err++;
      $display("FAIL reset_mid_count: %0d valid pulses after reset, required 1", n_valid - v0);
    end
    apply_reset();
  endtask

  task automatic test_ena();
    for (int i = 0; i < 3; i++) rise_seg(62, 63);
    rise_seg(62, 20);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_vec++;
      if (valid_o !== 1'b0 || glitch_o !== 1'b0) begin
        n_err++;
        $display("FAIL ena_pulses: valid_o=%0b glitch_o=%0b, required 0/0", valid_o, glitch_o);
      end
      n_vec++;
      if (period_o !== BW'(125) || high_o !== BW'(62) || silent_o !== 1'b0) begin
        n_err++;
        $display("FAIL ena_hold: period_o=%0d high_o=%0d silent_o=%0b, required 125/62/0",
                 period_o, high_o, silent_o);
      end
    end
    ena    = 1'b1;
    m_meas = 1'b0;
    tick(33);
    rise_seg(62, 63);   // first rise after re-enable: no report
    rise_seg(62, 63);
    rise_seg(10, 20);
    check_drained("ena");
    apply_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    pwm_i = 1'b0;
    p_h   = 0;
    p_l   = 0;
    model_reset();
    test_reset();
    test_square();
    test_glitch();
    test_duty();
    test_timeout();
    test_const_high();
    test_reset_mid();
    test_ena();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pwm_tone_decoder.md
PWM_TONE_DECODER -- requirements
Module: pwm_tone_decoder

Interface
REQ-001 SHALL have parameter BW, default 24, counter and output width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 24'd2400000, cycles without a rising edge before the input is declared silent; legal range MIN_PERIOD < TIMEOUT < 2^BW-1.
REQ-003 SHALL have parameter MIN_PERIOD, default 24'd4, shortest accepted period in clk cycles.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port ena, input, 1, decoder enable.
REQ-007 SHALL have port pwm_i, input, 1, asynchronous PWM tone input, the same format as the tone generator's pwm output.
REQ-008 SHALL have port period_o, output, BW, last accepted period in clk cycles.
REQ-009 SHALL have port high_o, output, BW, high-time of that period in clk cycles.
REQ-010 SHALL have port valid_o, output, 1, one-cycle pulse when period_o and high_o update.
REQ-011 SHALL have port glitch_o, output, 1, one-cycle pulse when a period is rejected.
REQ-012 SHALL have port silent_o, output, 1, level; 1 = no tone present.

Function
REQ-013 SHALL pass pwm_i through a 2-flop synchronizer; all logic uses only the synchronized signal s.
REQ-014 SHALL detect a rise when s=1 and its previous registered value was 0.
REQ-015 SHALL implement states IDLE, MEASURE.
REQ-016 IDLE: on a rise, SHALL load per_cnt=1 and hi_cnt=1, then go to MEASURE; SHALL emit no valid_o for this first rise.
REQ-017 MEASURE, no rise: SHALL increment per_cnt; SHALL increment hi_cnt only while s=1.
REQ-018 MEASURE, rise with per_cnt >= MIN_PERIOD: SHALL register period_o=per_cnt and high_o=hi_cnt; SHALL pulse valid_o; SHALL clear silent_o; SHALL reload both counters to 1.
REQ-019 MEASURE, rise with per_cnt < MIN_PERIOD: SHALL pulse glitch_o; SHALL leave period_o, high_o and silent_o unchanged; SHALL reload both counters to 1; SHALL stay in MEASURE.
REQ-020 MEASURE, per_cnt == TIMEOUT with no rise in the same cycle: SHALL go to IDLE; SHALL set silent_o=1; SHALL clear period_o and high_o to 0; SHALL not pulse valid_o.
REQ-021 A rise in the cycle where per_cnt == TIMEOUT SHALL take priority over the timeout and be handled per REQ-018/019.
REQ-022 Counters SHALL saturate at 2^BW-1 and never wrap.
REQ-023 For a steady input with period P and high-time H (P >= MIN_PERIOD, P < TIMEOUT), every valid_o after the first SHALL report period_o=P and high_o=H exactly.
REQ-024 Latency: valid_o SHALL be high in the cycle following the 3rd clk edge after the edge that first samples pwm_i high.
REQ-025 valid_o and glitch_o SHALL never be high in the same cycle.
REQ-026 ena=0 SHALL force IDLE and clear the counters; outputs SHALL hold, except valid_o and glitch_o, which SHALL be 0.
REQ-027 The synchronizer SHALL run regardless of ena.
REQ-028 On return of ena=1, the first rise SHALL be handled per REQ-016.
REQ-029 A constant-high or constant-low input SHALL reach silent per REQ-020.

Reset
REQ-030 rst_n=0 SHALL, asynchronously and in any state (including mid-measurement), set: state=IDLE, synchronizer=0, counters=0, period_o=0, high_o=0, valid_o=0, glitch_o=0, silent_o=1.
REQ-031 After rst_n deasserts, the first rise SHALL be treated per REQ-016.

Verification
REQ-032 Square wave, P=125, H=62, ena=1 -> first rise no valid_o; each later rise valid_o with period_o=125, high_o=62, silent_o=0.
REQ-033 Single pwm_i pulse 1 cycle wide, injected 2 cycles after a rise, inside a P=125 stream -> glitch_o pulse; period_o and high_o keep 125/62; next valid period reported correctly.
REQ-034 TIMEOUT=200 (override), tone P=50 then pwm_i held low -> silent_o=1 and period_o=0 exactly 200 cycles after the last rise's counter reload; no valid_o.
REQ-035 rst_n pulsed low mid-period -> all outputs at reset values immediately; the next two rises produce exactly one valid_o.
REQ-036 Duty extremes, P=125, H=1 and H=124 -> high_o=1 and high_o=124; pwm_i rising on a known edge -> valid_o timing per REQ-024.
REQ-037 ena dropped for 10 cycles mid-stream -> no valid_o during the drop; first rise after ena=1 gives no valid_o; second rise gives a correct valid_o.
